shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Multi-pass sequencer for the `shift_right` chunk-shift datapath. A single `shift_right` stage shifts a 50-bit word right by at most 4 five-bit chunks per pass. This block accepts a request of 0–10 chunks through a valid/ready handshake and iterates the datapath over registered passes of ≤4 chunks. It returns the fully shifted word through a second valid/ready handshake. It sits between the operand-alignment front end and any consumer that needs shifts longer than one datapath pass.

## Interface
- Parameters: none. All widths are fixed by the datapath and held as constants in the package.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst_n` input 1 — reset is synchronous and active-low.
- `in_valid` input 1 — request valid.
- `in_ready` output 1 — request accepted when `in_valid & in_ready` at a rising edge.
- `in_data` input 50 — word to shift.
- `in_shift` input 4 — total shift in chunks; 0–10 legal.
- `in_fill` input 5 — chunk pattern inserted at the top on every pass.
- `out_valid` output 1 — result valid.
- `out_ready` input 1 — consumer accepts when `out_valid & out_ready`.
- `out_data` output 50 — shifted word.
- `out_err` output 1 — request was illegal (`in_shift` > 10); qualified by `out_valid`.
- `busy` output 1 — high in SHIFT and DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On accept, latch `in_data`, `in_fill`, and `rem = min(in_shift, 10)`.
  - Set `err = (in_shift > 10)`.
  - Next state is DONE if `rem` == 0, otherwise SHIFT.
- **SHIFT**
  - `step = min(rem, 4)` drives the datapath shift select. `step` never exceeds 4.
  - `data <= shift_right(data, step, fill)`, i.e. `data >> (5*step)` with the top `step` chunks set to `fill`.
  - `rem <= rem - step`.
  - When `rem - step` == 0, go to DONE.
- **DONE**
  - `out_valid` = 1; `out_data`/`out_err` are held stable.
  - On `out_ready`, go to IDLE.
- Illegal shift (>10): saturated to 10, so `out_data` = `{10{fill}}` and `out_err` = 1.
- Datapath validity check: the `shift_right` validity output must be 1 for every step used. If it is ever 0 during SHIFT, set the registered `err` (defensive; unreachable by construction).
- Arithmetic: `rem` is 4 bits unsigned and never underflows, because `step` ≤ `rem`.

## Timing
- Reset values (sync, `rst_n` = 0 at an edge): state = IDLE, `out_valid` = 0, `out_data` = 0, `out_err` = 0, `busy` = 0.
- `in_ready` is forced 0 while `rst_n` is low.
- Passes: `p = ceil(rem/4)`. So shift 0 → 0 passes, 1–4 → 1, 5–8 → 2, 9–10 → 3.
- Latency: `out_valid` rises `1 + p` cycles after the accepting edge.
  - Shift 0: next cycle.
  - Shift 10: 4 cycles.
- No same-cycle turnaround: after the output handshake, `in_ready` returns 1 in the following cycle. Throughput is one request per `2 + p` cycles minimum.
- `in_valid`/`in_data` changes outside IDLE are ignored. No buffering.
- Backpressure: `out_valid` stays high indefinitely while `out_ready` = 0, with `out_data` unchanged.
- Reset mid-operation (SHIFT or DONE): the pending result is discarded with no output handshake, and the block is in IDLE the next cycle.

## Structure
- Package `shift_ctrl_pkg` holds:
  - `CHUNK_W` = 5, `NUM_CHUNKS` = 10, `WORD_W` = 50, `MAX_STEP` = 4.
  - State enum `shift_seq_state_t` {IDLE, SHIFT, DONE}.
- One sub-module instance: the existing `shift_right` datapath (3-bit shift select, 5-bit fill), fed from the internal data register.
- All control (`rem`, `step`, state, err) lives in this block.

## Test plan
- `in_data` = 50'h0_0000_0001_23FF, `in_shift` = 0 → `out_data` = 50'h0_0000_0001_23FF, `out_err` = 0, `out_valid` 1 cycle after accept.
- `in_data` = 50'h3_FFFF_FFFF_FFFF, `in_shift` = 4, `in_fill` = 0 → `out_data` = 50'h0_0000_3FFF_FFFF, latency 2.
- `in_data` = 0, `in_shift` = 9, `in_fill` = 5'h1F → `out_data` = 50'h3_FFFF_FFFF_FFE0, latency 4 (passes of 4, 4, 1).
- `in_shift` = 12, `in_fill` = 5'b10101 → `out_data` = `{10{5'b10101}}`, `out_err` = 1, latency 4.
- Shift 5 with `out_ready` held 0 for 5 cycles while a second `in_valid` is held:
  - `out_valid` and `out_data` stay stable; `in_ready` = 0.
  - The second request is accepted only the cycle after the output handshake.
- `rst_n` low for one edge during SHIFT of a shift-10 request → IDLE next cycle, `out_valid` = 0, `out_data` = 0, and a new shift-1 request completes normally.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared constants, state type and helpers for the multi-pass chunk-shift sequencer.
package shift_ctrl_pkg;

  localparam int CHUNK_W    = 5;
  localparam int NUM_CHUNKS = 10;
  localparam int WORD_W     = 50;
  localparam int MAX_STEP   = 4;
  localparam int REM_W      = 4;
  localparam int STEP_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_seq_state_t;

  // Clamp a requested chunk count to the word length; longer shifts fill the word.
  function automatic logic [REM_W-1:0] sat_shift(input logic [REM_W-1:0] req);
    return (req > REM_W'(NUM_CHUNKS)) ? REM_W'(NUM_CHUNKS) : req;
  endfunction

  // Chunks handled by one datapath pass.
  function automatic logic [STEP_W-1:0] pass_step(input logic [REM_W-1:0] rem);
    return (rem > REM_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : rem[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/shift_right.sv
// Single-pass datapath: shift a word right by 0-4 chunks, inserting fill at the top.
module shift_right
  import shift_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0]  data,
  input  logic [STEP_W-1:0]  shift,
  input  logic [CHUNK_W-1:0] fill,
  output logic [WORD_W-1:0]  result,
  output logic               valid
);

  // Select the shifted word; selects above MAX_STEP pass data through and flag invalid.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result = data;
    valid  = 1'b1;
    case (shift)
      3'd0: result = data;
      3'd1: result = {fill, data[WORD_W-1:CHUNK_W]};
      3'd2: result = {fill, fill, data[WORD_W-1:2*CHUNK_W]};
      3'd3: result = {fill, fill, fill, data[WORD_W-1:3*CHUNK_W]};
      3'd4: result = {fill, fill, fill, fill, data[WORD_W-1:4*CHUNK_W]};
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-pass sequencer: iterates the shift_right datapath in passes of up to
// four chunks to deliver shifts of 0-10 chunks over valid/ready handshakes.
module shift_right_seq
  import shift_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [REM_W-1:0]   in_shift,
  input  logic [CHUNK_W-1:0] in_fill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_err,
  output logic               busy
);

  shift_seq_state_t   state_q, state_d;
  logic [WORD_W-1:0]  data_q;
  logic [CHUNK_W-1:0] fill_q;
  logic [REM_W-1:0]   rem_q;
  logic               err_q;

  logic [STEP_W-1:0]  step;
  logic [REM_W-1:0]   rem_next;
  logic [REM_W-1:0]   req_rem;
  logic [WORD_W-1:0]  dp_result;
  logic               dp_valid;
  logic               accept;

  assign step     = pass_step(rem_q);
  assign rem_next = rem_q - REM_W'(step);
  assign req_rem  = sat_shift(in_shift);

  assign in_ready  = rst_n && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_err   = err_q;

  shift_right u_shift_right (
    .data   (data_q),
    .shift  (step),
    .fill   (fill_q),
    .result (dp_result),
    .valid  (dp_valid)
  );

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (req_rem == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_next == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand and remaining-count registers; reset clears the visible result too.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q <= in_data;
            fill_q <= in_fill;
            rem_q  <= req_rem;
            err_q  <= (in_shift > REM_W'(NUM_CHUNKS));
          end
        end
        SHIFT: begin
          data_q <= dp_result;
          rem_q  <= rem_next;
          // Defensive: a pass select the datapath rejects marks the result bad.
          if (!dp_valid) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed requests, a queue-based
// reference model and a per-cycle output comparator.
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] in_data;
  logic [3:0]  in_shift;
  logic [4:0]  in_fill;
  logic        out_valid;
  logic        out_ready;
  logic [49:0] out_data;
  logic        out_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [49:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  shift_right_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Whole-request reference: shift by the clamped chunk count in one step.
  function automatic exp_t model(input logic [49:0] d, input logic [3:0] s, input logic [4:0] f);
    exp_t e;
    int   n;
    n      = (s > 4'd10) ? 10 : int'(s);
    e.err  = (s > 4'd10);
    e.data = (n >= 10) ? 50'd0 : (d >> (5 * n));
    for (int i = 0; i < n; i++) e.data[49 - 5*i -: 5] = f;
    return e;
  endfunction

  // Output comparator: whenever a result is presented it must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
        check("out_err", 64'(out_err), 64'(exp_q[0].err));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Issue one request (caller is just after a rising edge) and verify latency and turnaround.
  task automatic run_req(input string name, input logic [49:0] d, input logic [3:0] s,
                         input logic [4:0] f, input int exp_lat);
    int lat;
    in_valid = 1'b1; in_data = d; in_shift = s; in_fill = f;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back(model(d, s, f));
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check({name, "_released"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    exp_t pin;
    int   lat;
    logic [49:0] held;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_fill = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Hand-computed values that pin the model itself.
    pin = model(50'h0_0000_0001_23FF, 4'd0, 5'h00);
    check("pin_shift0", 64'(pin.data), 64'h0_0000_0001_23FF);
    pin = model(50'h3_FFFF_FFFF_FFFF, 4'd4, 5'h00);
    check("pin_shift4", 64'(pin.data), 64'h0_0000_3FFF_FFFF);
    pin = model(50'h0, 4'd9, 5'h1F);
    check("pin_shift9", 64'(pin.data), 64'h3_FFFF_FFFF_FFE0);
    pin = model(50'h0, 4'd12, 5'b10101);
    check("pin_shift12", 64'({pin.err, pin.data}), {13'd0, 1'b1, {10{5'b10101}}});
    pin = model(50'h3_FFFF_FFFF_FFFF, 4'd5, 5'h00);
    check("pin_shift5", 64'(pin.data), 64'h0_0000_01FF_FFFF);
    pin = model(50'h1234, 4'd1, 5'h1F);
    check("pin_shift1", 64'(pin.data), 64'h3_E000_0000_0091);

    run_req("s0",  50'h0_0000_0001_23FF, 4'd0,  5'h00,    1);
    run_req("s4",  50'h3_FFFF_FFFF_FFFF, 4'd4,  5'h00,    2);
    run_req("s9",  50'h0,                4'd9,  5'h1F,    4);
    run_req("s12", 50'h2_5A5A_1234_ABCD, 4'd12, 5'b10101, 4);
    run_req("s8",  50'h1_2345_6789_ABCD, 4'd8,  5'h0C,    3);
    run_req("s10", 50'h3_0F0F_F0F0_1234, 4'd10, 5'h03,    4);

    // Backpressure with a second request waiting.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 50'h3_FFFF_FFFF_FFFF; in_shift = 4'd5; in_fill = 5'h00;
    @(posedge clk);
    exp_q.push_back(model(50'h3_FFFF_FFFF_FFFF, 4'd5, 5'h00));
    #1 in_data = 50'h1234; in_shift = 4'd1; in_fill = 5'h1F;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", 64'(lat), 64'd3);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_stable", 64'(out_data), 64'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_turnaround", 64'({out_valid, in_ready, busy}), 64'b010);
    @(posedge clk);
    exp_q.push_back(model(50'h1234, 4'd1, 5'h1F));
    #1 in_valid = 1'b0;
    check("bp_second_accepted", 64'(busy), 64'd1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_second_latency", 64'(lat), 64'd2);
    @(posedge clk); #1;

    // Reset in the middle of a long shift.
    in_valid = 1'b1; in_data = 50'h1_1111_2222_3333; in_shift = 4'd10; in_fill = 5'h07;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_req("post_rst_s1", 50'h0_0000_0000_0020, 4'd1, 5'h00, 2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
